mem_stage_lsu: RTL and testbench

Load/store unit of the MEM pipeline stage, directly upstream of the word-addressed data RAM. Converts EX/MEM byte-addressed requests (byte/half/word, signed/unsigned) into RAM word accesses. Sub-word stores are done as a 2-cycle read-modify-write with a pipeline stall. Registered load results go to the MEM/WB boundary.

---
 rtl/mips_mem_defs.sv | 16 +
 rtl/mem_stage_lsu_if.sv | 35 +++
 rtl/mem_stage_lsu_lane_align.sv | 40 ++++
 rtl/mem_stage_lsu.sv | 154 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_defs.sv
// Shared MEM-stage definitions: access size encodings, LSU FSM states, default RAM depth.
package mips_mem_defs;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned MEM_DEPTH_DEFAULT = 100;
  localparam int unsigned ADDR_W_DEFAULT    = 32;

  typedef enum logic {
    LSU_IDLE   = 1'b0,
    LSU_RMW_WR = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// EX/MEM request, MEM/WB result and data-RAM port bundle of the MEM-stage LSU.
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              stall;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [4:0]        wb_rd;
  logic              exc_misalign;
  logic [31:0]       ram_addr;
  logic [31:0]       ram_wd;
  logic              ram_we;
  logic [31:0]       ram_rd;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  stall, wb_valid, wb_data, wb_rd, exc_misalign,
    input  ram_addr, ram_wd, ram_we,
    output ram_rd
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output stall, wb_valid, wb_data, wb_rd, exc_misalign,
    output ram_addr, ram_wd, ram_we,
    input  ram_rd
  );
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Little-endian lane logic: extract+extend a loaded byte/half, or merge store data into a word.
module lsu_lane_align
  import mips_mem_defs::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] word_in,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shamt      = 5'd0;
    load_data  = word_in;
    merge_data = word_in;
    byte_sel   = 8'(word_in >> {lane, 3'b000});
    half_sel   = 16'(word_in >> {lane[1], 4'b0000});
    case (size)
      SZ_BYTE: begin
        shamt      = {lane, 3'b000};
        load_data  = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merge_data = (word_in & ~(32'h0000_00FF << shamt)) | ({24'd0, wdata[7:0]} << shamt);
      end
      SZ_HALF: begin
        // Half lane is picked by addr[1]; addr[0] is ignored here.
        shamt      = {lane[1], 4'b0000};
        load_data  = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_data = (word_in & ~(32'h0000_FFFF << shamt)) | ({16'd0, wdata} << shamt);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word RAM access, 2-cycle read-modify-write for sub-word stores.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses via exc_misalign.
module mem_stage_lsu
  import mips_mem_defs::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_lsu_if.slave  bus
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  lsu_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx, idx_q;
  logic              in_range;
  logic [31:0]       merge_q;
  logic [1:0]        lane_q, size_q;
  logic [15:0]       data_q;
  logic              misalign_c, capture_c, load_fire_c;
  logic [1:0]        align_size, align_lane;
  logic [31:0]       align_word, load_data, merge_data;
  logic              stall_c, ram_we_c;
  logic [31:0]       ram_wd_c, ram_addr_c;
  logic              wb_valid_q;
  logic [31:0]       wb_data_q;
  logic [4:0]        wb_rd_q;

  assign idx      = bus.req_addr[ADDR_W-1:2];
  assign in_range = 32'(idx) < 32'(MEM_DEPTH);

`ifdef MEM_MISALIGN_TRAP_EN
  logic exc_q;
  assign misalign_c = (state_q == LSU_IDLE) && bus.req_valid &&
                      (((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                       (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exc_q <= 1'b0;
    else      exc_q <= misalign_c;
  end
  assign bus.exc_misalign = exc_q;
`else
  assign misalign_c       = 1'b0;
  assign bus.exc_misalign = 1'b0;
`endif

  assign load_fire_c = (state_q == LSU_IDLE) && bus.req_valid && !bus.req_we && !misalign_c;

  lsu_lane_align u_align (
    .size        (align_size),
    .lane        (align_lane),
    .is_unsigned (bus.req_unsigned),
    .word_in     (align_word),
    .wdata       (data_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LSU_IDLE;
    else      state_q <= state_d;
  end

  // Next state and RAM-side drive; everything RAM-facing is forced low during reset.
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    capture_c  = 1'b0;
    ram_we_c   = 1'b0;
    ram_wd_c   = 32'd0;
    ram_addr_c = 32'd0;
    align_word = bus.ram_rd;
    align_size = bus.req_size;
    align_lane = bus.req_addr[1:0];
    case (state_q)
      LSU_IDLE: begin
        if (bus.req_valid && !misalign_c && in_range) begin
          ram_addr_c = 32'(idx);
          if (bus.req_we) begin
            if (!bus.req_size[1]) begin
              stall_c   = 1'b1;
              capture_c = 1'b1;
              state_d   = LSU_RMW_WR;
            end else begin
              ram_we_c = 1'b1;
              ram_wd_c = bus.req_wdata;
            end
          end
        end
      end
      LSU_RMW_WR: begin
        align_word = merge_q;
        align_size = size_q;
        align_lane = lane_q;
        ram_addr_c = 32'(idx_q);
        ram_wd_c   = merge_data;
        ram_we_c   = 1'b1;
        state_d    = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (!rst) begin
      stall_c    = 1'b0;
      ram_we_c   = 1'b0;
      ram_wd_c   = 32'd0;
      ram_addr_c = 32'd0;
    end
  end

  assign bus.stall    = stall_c;
  assign bus.ram_we   = ram_we_c;
  assign bus.ram_wd   = ram_wd_c;
  assign bus.ram_addr = ram_addr_c;

  // RMW capture of the old word and the store's index/lane/size/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      merge_q <= 32'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      data_q  <= 16'd0;
    end else if (capture_c) begin
      merge_q <= bus.ram_rd;
      idx_q   <= idx;
      lane_q  <= bus.req_addr[1:0];
      size_q  <= bus.req_size;
      data_q  <= bus.req_wdata[15:0];
    end
  end

  // MEM/WB load result; out-of-range loads complete with zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_rd_q    <= 5'd0;
    end else begin
      wb_valid_q <= load_fire_c;
      if (load_fire_c) begin
        wb_data_q <= in_range ? load_data : 32'd0;
        wb_rd_q   <= bus.req_rd;
      end
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table plus reset/pulse sequences.
module tb_mem_stage_lsu;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   we_cnt;
  logic [31:0] mem [0:99];

  mem_stage_lsu_if #(.ADDR_W(32)) bus ();

  mem_stage_lsu #(.MEM_DEPTH(100), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ram_rd = (bus.ram_addr < 32'd100) ? mem[bus.ram_addr[6:0]] : 32'd0;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      we_cnt <= we_cnt + 1;
      if (bus.ram_addr < 32'd100) mem[bus.ram_addr[6:0]] <= bus.ram_wd;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          stalls;
    logic        exp_we;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_exc;
    logic        chk_mem;
    int          mem_idx;
    logic [31:0] mem_val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                              input logic [4:0] rd, input logic [31:0] exp_data);
    vec_t v;
    v = '{we:1'b0, size:size, uns:uns, addr:addr, wdata:32'd0, rd:rd, stalls:0, exp_we:1'b0,
          exp_valid:1'b1, exp_data:exp_data, exp_exc:1'b0, chk_mem:1'b0, mem_idx:0, mem_val:32'd0};
    return v;
  endfunction

  function automatic vec_t st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                              input int mem_idx, input logic [31:0] mem_val);
    vec_t v;
    v = '{we:1'b1, size:size, uns:1'b0, addr:addr, wdata:wdata, rd:5'd0, stalls:(size[1] ? 0 : 1),
          exp_we:1'b1, exp_valid:1'b0, exp_data:32'd0, exp_exc:1'b0, chk_mem:1'b1,
          mem_idx:mem_idx, mem_val:mem_val};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one op at a negedge, ride out any stall, then sample the result at the following negedge.
  task automatic run_op(input int id, input vec_t v);
    int stalls;
    int we0;
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_rd       = v.rd;
    we0    = we_cnt;
    stalls = 0;
    #1;
    while (bus.stall && stalls < 4) begin
      stalls++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check($sformatf("op%0d stall_cycles", id), 32'(stalls), 32'(v.stalls));
    check($sformatf("op%0d ram_we_seen", id), 32'(we_cnt != we0), 32'(v.exp_we));
    check($sformatf("op%0d wb_valid", id), 32'(bus.wb_valid), 32'(v.exp_valid));
    check($sformatf("op%0d exc_misalign", id), 32'(bus.exc_misalign), 32'(v.exp_exc));
    if (v.exp_valid) begin
      check($sformatf("op%0d wb_data", id), bus.wb_data, v.exp_data);
      check($sformatf("op%0d wb_rd", id), 32'(bus.wb_rd), 32'(v.rd));
    end
    if (v.chk_mem) check($sformatf("op%0d ram_word", id), mem[v.mem_idx], v.mem_val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    we_cnt   = 0;
    for (int i = 0; i < 100; i++) mem[i] = 32'd0;

    vecs.push_back(st(W, 32'h8, 32'hDEADBEEF, 2, 32'hDEADBEEF));
    vecs.push_back(ld(B, 1'b0, 32'hB, 5'd5, 32'hFFFFFFDE));
    vecs.push_back(ld(B, 1'b1, 32'hB, 5'd6, 32'h000000DE));
    vecs.push_back(st(B, 32'h9, 32'hAAAAAA55, 2, 32'hDEAD55EF));
    vecs.push_back(ld(W, 1'b0, 32'h8, 5'd7, 32'hDEAD55EF));
    vecs.push_back(st(H, 32'h6, 32'hFFFF1234, 1, 32'h12340000));
    vecs.push_back(ld(H, 1'b1, 32'h6, 5'd8, 32'h00001234));
    vecs.push_back(st(H, 32'hC, 32'h00008000, 3, 32'h00008000));
    vecs.push_back(ld(H, 1'b0, 32'hC, 5'd9, 32'hFFFF8000));
    vecs.push_back(ld(B, 1'b0, 32'h8, 5'd10, 32'hFFFFFFEF));
    vecs.push_back(ld(H, 1'b0, 32'hA, 5'd11, 32'hFFFFDEAD));
    v = st(W, 32'd400, 32'h11111111, 0, 32'd0);
    v.exp_we = 1'b0; v.chk_mem = 1'b0;
    vecs.push_back(v);
    v = st(B, 32'd400, 32'h22, 0, 32'd0);
    v.exp_we = 1'b0; v.chk_mem = 1'b0; v.stalls = 0;
    vecs.push_back(v);
    vecs.push_back(ld(W, 1'b0, 32'd400, 5'd12, 32'h00000000));
    vecs.push_back(st(B, 32'd399, 32'h0000007F, 99, 32'h7F000000));
    vecs.push_back(ld(B, 1'b0, 32'd399, 5'd13, 32'h0000007F));
    vecs.push_back(ld(2'b11, 1'b0, 32'h8, 5'd14, 32'hDEAD55EF));
    vecs.push_back(st(W, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D));
`ifdef MEM_MISALIGN_TRAP_EN
    v = ld(W, 1'b0, 32'h2, 5'd15, 32'd0);
    v.exp_valid = 1'b0; v.exp_exc = 1'b1;
    vecs.push_back(v);
    v = ld(H, 1'b0, 32'h3, 5'd16, 32'd0);
    v.exp_valid = 1'b0; v.exp_exc = 1'b1;
    vecs.push_back(v);
`else
    vecs.push_back(ld(W, 1'b0, 32'h2, 5'd15, 32'hCAFEF00D));
    vecs.push_back(ld(H, 1'b0, 32'h3, 5'd16, 32'hFFFFCAFE));
`endif
    vecs.push_back(ld(W, 1'b0, 32'h4, 5'd17, 32'h12340000));

    // Reset asserted with a live word store presented: RAM side must stay quiet.
    rst              = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = W;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h8;
    bus.req_wdata    = 32'h01010101;
    bus.req_rd       = 5'd1;
    repeat (2) @(negedge clk);
    #1;
    check("reset ram_we", 32'(bus.ram_we), 32'd0);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset ram_addr", bus.ram_addr, 32'd0);
    check("reset ram_wd", bus.ram_wd, 32'd0);
    check("reset wb_valid", 32'(bus.wb_valid), 32'd0);
    check("reset wb_data", bus.wb_data, 32'd0);
    check("reset wb_rd", 32'(bus.wb_rd), 32'd0);
    check("reset exc_misalign", 32'(bus.exc_misalign), 32'd0);
    check("reset ram_word2", mem[2], 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst           = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_op(i, vecs[i]);

    // wb_valid is a single-cycle pulse; data and rd hold while idle.
    @(posedge clk);
    @(negedge clk);
    check("idle wb_valid", 32'(bus.wb_valid), 32'd0);
    check("idle wb_data hold", bus.wb_data, 32'h12340000);
    check("idle wb_rd hold", 32'(bus.wb_rd), 32'd17);
    check("idle exc_misalign", 32'(bus.exc_misalign), 32'd0);

    // Reset during the write cycle of a byte store abandons the write.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = B;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h00000099;
    bus.req_rd    = 5'd0;
    #1;
    check("rmw first stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rmw write ram_we", 32'(bus.ram_we), 32'd1);
    check("rmw write ram_wd", bus.ram_wd, 32'hCAFEF099);
    check("rmw write stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    #1;
    check("mid-rmw reset ram_we", 32'(bus.ram_we), 32'd0);
    check("mid-rmw reset ram_addr", bus.ram_addr, 32'd0);
    check("mid-rmw reset ram_wd", bus.ram_wd, 32'd0);
    check("mid-rmw reset stall", 32'(bus.stall), 32'd0);
    check("mid-rmw reset wb_valid", 32'(bus.wb_valid), 32'd0);
    check("mid-rmw reset wb_data", bus.wb_data, 32'd0);
    check("mid-rmw reset wb_rd", 32'(bus.wb_rd), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid-rmw reset ram_word0", mem[0], 32'hCAFEF00D);
    rst = 1'b1;
    @(negedge clk);
    run_op(100, ld(W, 1'b0, 32'h0, 5'd3, 32'hCAFEF00D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
